cnn_conv1_acc_sat: RTL and testbench

Downstream stage of the conv1 signed 9×14 product multiplier: consumes the 24-bit signed product stream for one output pixel and accumulates TAPS products plus a per-channel bias. It then rounds, shifts back to activation scale and saturates to a 9-bit signed activation. The result feeds the next layer's 9-bit multiplier operand through a valid/ready handshake.

---
 rtl/cnn_conv1_pkg.sv | 27 ++
 rtl/cnn_round_sat.sv | 40 ++++
 rtl/cnn_conv1_acc_sat.sv | 118 +++++++++++
 tb/tb_cnn_conv1_acc_sat.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_conv1_pkg.sv
// Shared widths, FSM state encoding and saturation-bound helpers for the conv1
// accumulate/round/saturate stage.
package cnn_conv1_pkg;

    localparam int DEF_PROD_W     = 24;
    localparam int DEF_ACC_W      = 32;
    localparam int DEF_TAPS       = 25;
    localparam int DEF_BIAS_W     = 14;
    localparam int DEF_FRAC_SHIFT = 8;
    localparam int DEF_OUT_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    function automatic int sat_hi(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/cnn_round_sat.sv
// Combinational round-half-up, arithmetic shift to activation scale and signed
// saturation. Define CNN_CONV1_ACC_RELU_EN to clamp negative results to zero.
module cnn_round_sat
    import cnn_conv1_pkg::*;
#(
    parameter int ACC_W      = DEF_ACC_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] o_res
);

    localparam logic signed [ACC_W-1:0] L_HALF = ACC_W'(1 << (FRAC_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] L_HI   = ACC_W'(sat_hi(OUT_W));
    localparam logic signed [ACC_W-1:0] L_LO   = ACC_W'(sat_lo(OUT_W));

    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_shr;
    logic signed [OUT_W-1:0] w_sat;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        w_rnd = i_acc + L_HALF;
        w_shr = w_rnd >>> FRAC_SHIFT;
        if (w_shr > L_HI) begin
            w_sat = L_HI[OUT_W-1:0];
        end else if (w_shr < L_LO) begin
            w_sat = L_LO[OUT_W-1:0];
        end else begin
            w_sat = w_shr[OUT_W-1:0];
        end
`ifdef CNN_CONV1_ACC_RELU_EN
        o_res = w_sat[OUT_W-1] ? '0 : w_sat;
`else
        o_res = w_sat;
`endif
    end

endmodule

// File: rtl/cnn_conv1_acc_sat.sv
// Accumulates one window of conv1 products plus bias, then rounds/saturates to a
// 9-bit activation behind a valid/ready handshake. Optional: CNN_CONV1_ACC_RELU_EN.
module cnn_conv1_acc_sat
    import cnn_conv1_pkg::*;
#(
    parameter int PROD_W     = DEF_PROD_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int TAPS       = DEF_TAPS,
    parameter int BIAS_W     = DEF_BIAS_W,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int OUT_W      = DEF_OUT_W
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] prod_din,
    input  logic                     prod_valid,
    input  logic                     prod_last,
    output logic                     prod_ready,
    input  logic signed [BIAS_W-1:0] bias_din,
    output logic signed [OUT_W-1:0]  res_dout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     err_len
);

    localparam int L_CNT_W = $clog2(TAPS + 2);
    localparam logic [L_CNT_W-1:0] L_CNT_TAPS = L_CNT_W'(TAPS);
    localparam logic [L_CNT_W-1:0] L_CNT_MAX  = L_CNT_W'(TAPS + 1);

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [L_CNT_W-1:0]       r_cnt;
    logic                     r_ready;
    logic signed [OUT_W-1:0]  r_res;
    logic                     r_valid;
    logic                     r_err;

    logic                     w_accept;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [OUT_W-1:0]  w_res;

    assign w_accept   = prod_valid & r_ready;
    assign w_prod_ext = ACC_W'(prod_din);
    assign w_bias_ext = ACC_W'(bias_din);

    cnn_round_sat #(
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_W      (OUT_W)
    ) u_round_sat (
        .i_acc (r_acc),
        .o_res (w_res)
    );

    // prod_ready is registered: low during reset, rises on the first clock in IDLE.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_res   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc <= w_bias_ext + w_prod_ext;
                        r_cnt <= L_CNT_W'(1);
                        if (prod_last) begin
                            r_state <= ST_FINAL;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_prod_ext;
                        if (r_cnt != L_CNT_MAX) begin
                            r_cnt <= r_cnt + L_CNT_W'(1);
                        end
                        if (prod_last) begin
                            r_state <= ST_FINAL;
                            r_ready <= 1'b0;
                        end
                    end
                end
                ST_FINAL: begin
                    r_res   <= w_res;
                    r_valid <= 1'b1;
                    r_err   <= (r_cnt != L_CNT_TAPS);
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign prod_ready = r_ready;
    assign res_dout   = r_res;
    assign res_valid  = r_valid;
    assign err_len    = r_err;

endmodule

// File: tb/tb_cnn_conv1_acc_sat.sv
// Self-checking bench for cnn_conv1_acc_sat: directed and random windows checked
// against an arithmetic reference model (floor-division rounding, clamp).
module tb_cnn_conv1_acc_sat;

    localparam int PW   = 24;
    localparam int BW   = 14;
    localparam int OW   = 9;
    localparam int TAPS = 25;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n = 1'b0;
    logic signed [PW-1:0] prod_din = '0;
    logic                 prod_valid = 1'b0;
    logic                 prod_last = 1'b0;
    logic                 prod_ready;
    logic signed [BW-1:0] bias_din = '0;
    logic signed [OW-1:0] res_dout;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic                 err_len;

    int total = 0;
    int bad   = 0;
    logic signed [PW-1:0] q_prod[$];

    always #5 ap_clk = ~ap_clk;

    cnn_conv1_acc_sat dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_din   (prod_din),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .bias_din   (bias_din),
        .res_dout   (res_dout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .err_len    (err_len)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: floor((sum + 128) / 256), clamp to the 9-bit signed range.
    function automatic longint ref_result(input longint sum);
        longint num;
        longint r;
        num = sum + 128;
        if (num >= 0) r = num / 256;
        else          r = -((-num + 255) / 256);
        if (r > 255)  r = 255;
        if (r < -256) r = -256;
`ifdef CNN_CONV1_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic fill(input int n, input int val);
        q_prod.delete();
        for (int i = 0; i < n; i++) q_prod.push_back(PW'(val));
    endtask

    // Drives q_prod as one window; entered and left at a falling edge.
    task automatic drive_window(input logic signed [BW-1:0] b, input bit bubbles);
        int n;
        int guard;
        n = q_prod.size();
        for (int i = 0; i < n; i++) begin
            if (bubbles && i > 0 && $urandom_range(0, 3) == 0) begin
                prod_valid = 1'b0;
                prod_din   = PW'($urandom);
                prod_last  = 1'($urandom);
                @(negedge ap_clk);
            end
            prod_valid = 1'b1;
            prod_din   = q_prod[i];
            prod_last  = (i == n - 1);
            bias_din   = (i == 0) ? b : BW'($urandom);
            guard = 0;
            while (!prod_ready && guard < 100) begin
                @(negedge ap_clk);
                guard++;
            end
            if (guard >= 100) chk("ready_timeout", 0, 1);
            @(negedge ap_clk);
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod_din   = PW'($urandom);
    endtask

    task automatic run_window(input logic signed [BW-1:0] b, input int hold, input bit bubbles, input string tag);
        longint sum;
        longint exp_res;
        logic signed [OW-1:0] held;
        sum = longint'(b);
        foreach (q_prod[i]) sum += longint'(q_prod[i]);
        exp_res = ref_result(sum);
        res_ready = 1'b0;
        drive_window(b, bubbles);
        chk({tag, "_final_valid"}, 64'(res_valid), 0);
        chk({tag, "_final_ready"}, 64'(prod_ready), 0);
        @(negedge ap_clk);
        chk({tag, "_valid"}, 64'(res_valid), 1);
        chk({tag, "_dout"}, 64'(res_dout), exp_res);
        chk({tag, "_err"}, 64'(err_len), 64'(q_prod.size() != TAPS));
        held = res_dout;
        for (int k = 0; k < hold; k++) begin
            @(negedge ap_clk);
            chk({tag, "_hold_dout"}, 64'(res_dout), 64'(held));
            chk({tag, "_hold_valid"}, 64'(res_valid), 1);
            chk({tag, "_hold_ready"}, 64'(prod_ready), 0);
            chk({tag, "_hold_err"}, 64'(err_len), 0);
        end
        res_ready = 1'b1;
        @(negedge ap_clk);
        chk({tag, "_done_valid"}, 64'(res_valid), 0);
        chk({tag, "_done_ready"}, 64'(prod_ready), 1);
        res_ready = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        // Reset state.
        repeat (3) @(negedge ap_clk);
        chk("rst_ready", 64'(prod_ready), 0);
        chk("rst_valid", 64'(res_valid), 0);
        chk("rst_dout", 64'(res_dout), 0);
        chk("rst_err", 64'(err_len), 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("idle_ready", 64'(prod_ready), 1);

        fill(TAPS, 256);
        run_window(0, 0, 0, "unit256");
        fill(TAPS, 1 << 20);
        run_window(0, 0, 0, "sat_pos");
        fill(TAPS, -(1 << 20));
        run_window(0, 0, 0, "sat_neg");

        fill(TAPS, 0); q_prod[0] = 256;
        run_window(128, 0, 0, "rnd_384");
        run_window(127, 0, 0, "rnd_383");
        q_prod[0] = -256;
        run_window(-128, 0, 0, "rnd_m384");

        fill(20, 256);
        run_window(0, 0, 0, "short20");
        fill(27, 256);
        run_window(0, 0, 0, "long27");

        fill(TAPS, 256);
        run_window(0, 10, 0, "bp");
        q_prod[3] = 1000;
        run_window(-300, 0, 0, "after_bp");

        // Reset after 12 accepted products discards the partial sum.
        fill(12, 256);
        for (int i = 0; i < 12; i++) begin
            prod_valid = 1'b1;
            prod_din   = q_prod[i];
            prod_last  = 1'b0;
            bias_din   = (i == 0) ? BW'(100) : BW'($urandom);
            @(negedge ap_clk);
        end
        prod_valid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(prod_ready), 0);
        chk("mid_rst_valid", 64'(res_valid), 0);
        chk("mid_rst_dout", 64'(res_dout), 0);
        chk("mid_rst_err", 64'(err_len), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        guard = 0;
        while (!prod_ready && guard < 20) begin
            @(negedge ap_clk);
            chk("post_rst_valid", 64'(res_valid), 0);
            guard++;
        end
        if (guard >= 20) chk("post_rst_timeout", 0, 1);
        fill(TAPS, 256);
        run_window(0, 0, 0, "post_rst");

        // Random windows: moderate values with bubbles, then full-range values.
        for (int w = 0; w < 8; w++) begin
            n = $urandom_range(TAPS - 2, TAPS + 2);
            q_prod.delete();
            for (int i = 0; i < n; i++) q_prod.push_back(PW'(int'($urandom_range(0, 4000)) - 2000));
            run_window(BW'($urandom), $urandom_range(0, 3), 1, "rand_mod");
        end
        for (int w = 0; w < 4; w++) begin
            q_prod.delete();
            for (int i = 0; i < TAPS; i++) q_prod.push_back(PW'($urandom));
            run_window(BW'($urandom), $urandom_range(0, 2), 1, "rand_full");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
